// File: rtl/output_gain_pkg.sv
// -----------------------------------------------------------------------------
// output_gain_pkg
// Shared constants and helpers for the output gain stage.
//   - GAIN_TABLE  : Q2.14 unsigned gain per gain_sel index (17 bits each)
//   - FRAC_BITS / ROUND_CONST : Q-format rounding constants
//   - SAMPLE_MAX / SAMPLE_MIN : 16-bit signed output limits
//   - phase_e     : three-phase sample sequencer states
//   - round_frac / is_sat / sat16 : product rounding and saturation helpers
// -----------------------------------------------------------------------------
package output_gain_pkg;

   localparam int GAIN_W      = 17;
   localparam int PROD_W      = 34;
   localparam int FRAC_BITS   = 14;
   localparam int ROUND_CONST = 8192;
   localparam int SAMPLE_MAX  = 32767;
   localparam int SAMPLE_MIN  = -32768;

   // Packed so it can be indexed directly by gain_sel; entry 7 is leftmost.
   localparam logic [7:0][GAIN_W-1:0] GAIN_TABLE = {
      17'd49152,   // 7
      17'd32768,   // 6
      17'd23170,   // 5
      17'd16384,   // 4 unity
      17'd11585,   // 3
      17'd8192,    // 2
      17'd4096,    // 1
      17'd0        // 0 mute
   };

   localparam logic signed [PROD_W-1:0] SAT_HI    = 34'(SAMPLE_MAX);
   localparam logic signed [PROD_W-1:0] SAT_LO    = 34'(SAMPLE_MIN);
   localparam logic signed [PROD_W-1:0] RND_ADD   = 34'(ROUND_CONST);

   typedef enum logic [1:0] {
      PH_CAP = 2'd0,
      PH_MUL = 2'd1,
      PH_OUT = 2'd2
   } phase_e;

   // Round half toward +inf: add half an LSB then arithmetic shift.
   function automatic logic signed [PROD_W-1:0] round_frac(input logic signed [PROD_W-1:0] p);
      logic signed [PROD_W-1:0] sum;
      sum = p + RND_ADD;
      return sum >>> FRAC_BITS;
   endfunction

   function automatic logic is_sat(input logic signed [PROD_W-1:0] r);
      return (r > SAT_HI) || (r < SAT_LO);
   endfunction

   function automatic logic [15:0] sat16(input logic signed [PROD_W-1:0] r);
      logic [15:0] v;
      if (r > SAT_HI) begin
         v = 16'h7FFF;
      end else if (r < SAT_LO) begin
         v = 16'h8000;
      end else begin
         v = r[15:0];
      end
      return v;
   endfunction

endpackage

// File: rtl/gain_ramp.sv
// -----------------------------------------------------------------------------
// gain_ramp
// Samples gain_sel on each capture phase, looks up the target gain and walks
// cur_gain toward it by RAMP_STEP per sample, snapping when within one step.
// Ports:
//   clk_144  in   system clock
//   reset    in   asynchronous active-high reset
//   gain_sel in   [2:0] gain table index
//   cap_en   in   high on the capture phase (one cycle per sample)
//   cur_gain out  [16:0] Q2.14 current gain, registered
// -----------------------------------------------------------------------------
module gain_ramp
   import output_gain_pkg::*;
#(
   parameter int RAMP_STEP = 64
) (
   input  logic              clk_144,
   input  logic              reset,
   input  logic [2:0]        gain_sel,
   input  logic              cap_en,
   output logic [GAIN_W-1:0] cur_gain
);

   localparam logic [GAIN_W-1:0] STEP = 17'(RAMP_STEP);

   logic [GAIN_W-1:0] target_q, target_d;
   logic [GAIN_W-1:0] cur_gain_q, cur_gain_d;
   logic [GAIN_W-1:0] dist_s;

   // Next target and next gain; the step heads toward the freshly sampled
   // target so a new selection takes effect on the same capture.
   always_comb begin
      target_d   = target_q;
      cur_gain_d = cur_gain_q;
      dist_s     = 17'd0;
      if (cap_en) begin
         target_d = GAIN_TABLE[gain_sel];
         if (target_d >= cur_gain_q) begin
            dist_s = target_d - cur_gain_q;
            if (dist_s <= STEP) begin
               cur_gain_d = target_d;
            end else begin
               cur_gain_d = cur_gain_q + STEP;
            end
         end else begin
            dist_s = cur_gain_q - target_d;
            if (dist_s <= STEP) begin
               cur_gain_d = target_d;
            end else begin
               cur_gain_d = cur_gain_q - STEP;
            end
         end
      end else begin
         target_d   = target_q;
         cur_gain_d = cur_gain_q;
      end
   end

   // Gain and target registers; reset returns the gain to mute.
   always_ff @(posedge clk_144 or posedge reset) begin
      if (reset) begin
         target_q   <= 17'd0;
         cur_gain_q <= 17'd0;
      end else begin
         target_q   <= target_d;
         cur_gain_q <= cur_gain_d;
      end
   end

   assign cur_gain = cur_gain_q;

endmodule

// File: rtl/output_gain.sv
// -----------------------------------------------------------------------------
// output_gain
// Post-filter gain stage: capture (ph 0), multiply (ph 1), round/saturate and
// strobe (ph 2). Gain ramps toward the selected table entry one step per
// sample. Optional clip indicator with hold, built when OUTPUT_GAIN_CLIP_EN is
// defined; otherwise clip is tied low.
// Ports:
//   clk_144   in   system clock, 3 clocks per audio sample
//   reset     in   asynchronous active-high reset
//   gain_sel  in   [2:0] gain setting index
//   gainIn    in   [15:0] signed input sample
//   gainOut   out  [15:0] signed gained, saturated sample
//   outStrobe out  one-cycle pulse when gainOut updates
//   clip      out  saturation indicator, held CLIP_HOLD samples
// -----------------------------------------------------------------------------
module output_gain
   import output_gain_pkg::*;
#(
   parameter int RAMP_STEP = 64,
   parameter int CLIP_HOLD = 4800
) (
   input  logic        clk_144,
   input  logic        reset,
   input  logic [2:0]  gain_sel,
   input  logic [15:0] gainIn,
   output logic [15:0] gainOut,
   output logic        outStrobe,
   output logic        clip
);

   phase_e                   ph_q, ph_d;
   logic [15:0]              in_q, in_d;
   logic signed [PROD_W-1:0] prod_q, prod_d;
   logic [15:0]              out_q, out_d;
   logic                     strobe_q, strobe_d;
   logic [GAIN_W-1:0]        cur_gain_s;
   logic signed [PROD_W-1:0] in_ext_s, gain_ext_s, rnd_s;

   gain_ramp #(
      .RAMP_STEP (RAMP_STEP)
   ) u_ramp (
      .clk_144  (clk_144),
      .reset    (reset),
      .gain_sel (gain_sel),
      .cap_en   (ph_q == PH_CAP),
      .cur_gain (cur_gain_s)
   );

   // Gain is unsigned, so it is zero-extended before the signed multiply.
   assign in_ext_s   = {{18{in_q[15]}}, in_q};
   assign gain_ext_s = {17'd0, cur_gain_s};
   assign rnd_s      = round_frac(prod_q);

   // Phase sequencing and datapath next-state.
   always_comb begin
      ph_d     = ph_q;
      in_d     = in_q;
      prod_d   = prod_q;
      out_d    = out_q;
      strobe_d = 1'b0;
      case (ph_q)
         PH_CAP: begin
            ph_d = PH_MUL;
            in_d = gainIn;
         end
         PH_MUL: begin
            ph_d   = PH_OUT;
            prod_d = in_ext_s * gain_ext_s;
         end
         PH_OUT: begin
            ph_d     = PH_CAP;
            out_d    = sat16(rnd_s);
            strobe_d = 1'b1;
         end
         default: begin
            ph_d = PH_CAP;
         end
      endcase
   end

   // Pipeline and output registers.
   always_ff @(posedge clk_144 or posedge reset) begin
      if (reset) begin
         ph_q     <= PH_CAP;
         in_q     <= 16'd0;
         prod_q   <= 34'sd0;
         out_q    <= 16'd0;
         strobe_q <= 1'b0;
      end else begin
         ph_q     <= ph_d;
         in_q     <= in_d;
         prod_q   <= prod_d;
         out_q    <= out_d;
         strobe_q <= strobe_d;
      end
   end

   assign gainOut   = out_q;
   assign outStrobe = strobe_q;

`ifdef OUTPUT_GAIN_CLIP_EN
   localparam int HOLD_W = $clog2(CLIP_HOLD + 1);

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              clip_q, clip_d;

   // Clip hold: saturation reloads the count; each clean output counts down
   // and clip drops on the output that brings the count to zero.
   always_comb begin
      hold_d = hold_q;
      clip_d = clip_q;
      if (ph_q == PH_OUT) begin
         if (is_sat(rnd_s)) begin
            hold_d = HOLD_W'(CLIP_HOLD);
            clip_d = 1'b1;
         end else if (hold_q != HOLD_W'(0)) begin
            hold_d = hold_q - HOLD_W'(1);
            clip_d = (hold_q != HOLD_W'(1));
         end else begin
            hold_d = HOLD_W'(0);
            clip_d = 1'b0;
         end
      end else begin
         hold_d = hold_q;
         clip_d = clip_q;
      end
   end

   // Clip hold registers.
   always_ff @(posedge clk_144 or posedge reset) begin
      if (reset) begin
         hold_q <= HOLD_W'(0);
         clip_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         clip_q <= clip_d;
      end
   end

   assign clip = clip_q;
`else
   // No detector built; CLIP_HOLD is only referenced to keep the parameter live.
   assign clip = 1'b0 & (CLIP_HOLD > 0);
`endif

endmodule

// File: tb/tb_output_gain.sv
module tb_output_gain;

   logic        clk_144 = 1'b0;
   logic        reset   = 1'b1;
   logic [2:0]  gain_sel = 3'd0;
   logic [15:0] gainIn   = 16'd0;
   logic [15:0] gainOut;
   logic        outStrobe;
   logic        clip;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef OUTPUT_GAIN_CLIP_EN
   localparam logic CLIP_ON = 1'b1;
`else
   localparam logic CLIP_ON = 1'b0;
`endif

   int sine_tab [8] = '{0, 23170, 32767, 23170, 0, -23170, -32767, -23170};

   output_gain #(
      .RAMP_STEP (64),
      .CLIP_HOLD (4800)
   ) dut (
      .clk_144   (clk_144),
      .reset     (reset),
      .gain_sel  (gain_sel),
      .gainIn    (gainIn),
      .gainOut   (gainOut),
      .outStrobe (outStrobe),
      .clip      (clip)
   );

   always #5 clk_144 = ~clk_144;

   // Reference: round(x*g/2^14) half toward +inf, clamped to 16-bit signed.
   function automatic logic [15:0] ref_gain(input int x, input int g);
      longint p;
      longint r;
      p = longint'(x) * longint'(g) + 64'sd8192;
      r = p >>> 14;
      if (r > 64'sd32767) r = 64'sd32767;
      if (r < -64'sd32768) r = -64'sd32768;
      return 16'(r);
   endfunction

   // Waits for the next strobe (bounded), sampling 1 time unit after each edge.
   task automatic wait_strobe(output int edges);
      edges = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk_144);
         #1;
         edges++;
         if (outStrobe === 1'b1) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL strobe_timeout: no outStrobe after %0d edges, required within 3", edges);
   endtask

   task automatic test_reset();
      int e;
      reset = 1'b1;
      repeat (3) @(posedge clk_144);
      #1;
      n_checks++;
      if (gainOut !== 16'd0) begin n_fail++; $display("FAIL reset_gainOut: got %0d required 0", gainOut); end
      n_checks++;
      if (outStrobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b required 0", outStrobe); end
      n_checks++;
      if (clip !== 1'b0) begin n_fail++; $display("FAIL reset_clip: got %b required 0", clip); end
      e = 0;
   endtask

   task automatic test_ramp_from_reset();
      int e;
      logic [15:0] exp_v;
      gain_sel = 3'd4;
      gainIn   = 16'd16384;
      @(negedge clk_144);
      reset = 1'b0;
      for (int k = 1; k <= 260; k++) begin
         wait_strobe(e);
         exp_v = 16'((k <= 256) ? 64 * k : 16384);
         n_checks++;
         if (gainOut !== exp_v) begin
            n_fail++;
            $display("FAIL ramp_s%0d: gainOut %0d required %0d", k, $signed(gainOut), $signed(exp_v));
         end
         n_checks++;
         if (e != 3) begin n_fail++; $display("FAIL ramp_cadence_s%0d: %0d edges required 3", k, e); end
      end
      @(posedge clk_144);
      #1;
      n_checks++;
      if (outStrobe !== 1'b0) begin n_fail++; $display("FAIL strobe_width: got %b required 0", outStrobe); end
      // realign: the next strobe is two edges away
      wait_strobe(e);
   endtask

   task automatic test_rounding();
      int e;
      int vin  [7] = '{-3, 3, 1000, -1, 1, -32768, 32767};
      int vexp [7] = '{-1, 2, 500, 0, 1, -16384, 16384};
      gain_sel = 3'd2;
      gainIn   = 16'd0;
      repeat (130) wait_strobe(e);
      for (int i = 0; i < 7; i++) begin
         gainIn = 16'(vin[i]);
         wait_strobe(e);
         n_checks++;
         if (gainOut !== 16'(vexp[i])) begin
            n_fail++;
            $display("FAIL round_in%0d: gainOut %0d required %0d", vin[i], $signed(gainOut), vexp[i]);
         end
      end
      n_checks++;
      if (clip !== 1'b0) begin n_fail++; $display("FAIL round_clip: got %b required 0", clip); end
   endtask

   task automatic test_pos_sat();
      int e;
      gain_sel = 3'd6;
      gainIn   = 16'd0;
      repeat (390) wait_strobe(e);
      gainIn = 16'd16383;
      wait_strobe(e);
      n_checks++;
      if (gainOut !== 16'd32766) begin n_fail++; $display("FAIL pos_edge_val: gainOut %0d required 32766", $signed(gainOut)); end
      n_checks++;
      if (clip !== 1'b0) begin n_fail++; $display("FAIL pos_edge_clip: got %b required 0", clip); end
      gainIn = 16'd16384;
      wait_strobe(e);
      n_checks++;
      if (gainOut !== 16'd32767) begin n_fail++; $display("FAIL pos_sat_min: gainOut %0d required 32767", $signed(gainOut)); end
      gainIn = 16'd20000;
      wait_strobe(e);
      n_checks++;
      if (gainOut !== 16'd32767) begin n_fail++; $display("FAIL pos_sat_val: gainOut %0d required 32767", $signed(gainOut)); end
      n_checks++;
      if (clip !== CLIP_ON) begin n_fail++; $display("FAIL pos_sat_clip: got %b required %b", clip, CLIP_ON); end
      gainIn = 16'd0;
`ifdef OUTPUT_GAIN_CLIP_EN
      for (int k = 1; k <= 4800; k++) begin
         wait_strobe(e);
         if (k == 1) begin
            n_checks++;
            if (gainOut !== 16'd0) begin n_fail++; $display("FAIL pos_zero_val: gainOut %0d required 0", $signed(gainOut)); end
         end
         if (k == 4799) begin
            n_checks++;
            if (clip !== 1'b1) begin n_fail++; $display("FAIL pos_hold_4799: clip %b required 1", clip); end
         end
         if (k == 4800) begin
            n_checks++;
            if (clip !== 1'b0) begin n_fail++; $display("FAIL pos_hold_4800: clip %b required 0", clip); end
         end
      end
`else
      repeat (3) wait_strobe(e);
      n_checks++;
      if (gainOut !== 16'd0) begin n_fail++; $display("FAIL pos_zero_val: gainOut %0d required 0", $signed(gainOut)); end
      n_checks++;
      if (clip !== 1'b0) begin n_fail++; $display("FAIL pos_noclip: clip %b required 0", clip); end
`endif
   endtask

   task automatic test_neg_sat();
      int e;
      gain_sel = 3'd7;
      gainIn   = 16'd0;
      repeat (260) wait_strobe(e);
      gainIn = 16'h8000;
      wait_strobe(e);
      n_checks++;
      if (gainOut !== 16'h8000) begin n_fail++; $display("FAIL neg_sat_val: gainOut %0d required -32768", $signed(gainOut)); end
      n_checks++;
      if (clip !== CLIP_ON) begin n_fail++; $display("FAIL neg_sat_clip: got %b required %b", clip, CLIP_ON); end
      gainIn = 16'd0;
`ifdef OUTPUT_GAIN_CLIP_EN
      repeat (4700) wait_strobe(e);
      n_checks++;
      if (clip !== 1'b1) begin n_fail++; $display("FAIL neg_hold_100: clip %b required 1", clip); end
      gainIn = 16'h8000;
      wait_strobe(e);
      n_checks++;
      if (clip !== 1'b1) begin n_fail++; $display("FAIL neg_retrig_clip: clip %b required 1", clip); end
      gainIn = 16'd0;
      for (int k = 1; k <= 4800; k++) begin
         wait_strobe(e);
         if (k == 4799) begin
            n_checks++;
            if (clip !== 1'b1) begin n_fail++; $display("FAIL neg_reload_4799: clip %b required 1", clip); end
         end
         if (k == 4800) begin
            n_checks++;
            if (clip !== 1'b0) begin n_fail++; $display("FAIL neg_reload_4800: clip %b required 0", clip); end
         end
      end
`else
      wait_strobe(e);
      n_checks++;
      if (clip !== 1'b0) begin n_fail++; $display("FAIL neg_noclip: clip %b required 0", clip); end
`endif
   endtask

   task automatic test_async_reset();
      int e;
      gainIn = 16'h8000;
      wait_strobe(e);
      n_checks++;
      if (gainOut !== 16'h8000) begin n_fail++; $display("FAIL pre_reset_val: gainOut %0d required -32768", $signed(gainOut)); end
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (gainOut !== 16'd0) begin n_fail++; $display("FAIL async_gainOut: got %0d required 0", $signed(gainOut)); end
      n_checks++;
      if (outStrobe !== 1'b0) begin n_fail++; $display("FAIL async_strobe: got %b required 0", outStrobe); end
      n_checks++;
      if (clip !== 1'b0) begin n_fail++; $display("FAIL async_clip: got %b required 0", clip); end
   endtask

   task automatic test_retarget();
      int e;
      int g;
      logic [15:0] exp_v;
      gain_sel = 3'd4;
      gainIn   = 16'd16384;
      @(negedge clk_144);
      reset = 1'b0;
      for (int k = 1; k <= 128; k++) begin
         wait_strobe(e);
         if (k == 1) begin
            n_checks++;
            if (e != 3) begin n_fail++; $display("FAIL post_reset_latency: %0d edges required 3", e); end
            n_checks++;
            if (gainOut !== 16'd64) begin n_fail++; $display("FAIL post_reset_first: gainOut %0d required 64", $signed(gainOut)); end
         end
      end
      n_checks++;
      if (gainOut !== 16'd8192) begin n_fail++; $display("FAIL retarget_start: gainOut %0d required 8192", $signed(gainOut)); end
      gain_sel = 3'd0;
      for (int j = 1; j <= 128; j++) begin
         gainIn = 16'(sine_tab[j % 8]);
         g = 8192 - 64 * j;
         exp_v = ref_gain(sine_tab[j % 8], g);
         wait_strobe(e);
         n_checks++;
         if (gainOut !== exp_v) begin
            n_fail++;
            $display("FAIL decay_s%0d: gainOut %0d required %0d", j, $signed(gainOut), $signed(exp_v));
         end
      end
      gainIn = 16'd16384;
      repeat (2) wait_strobe(e);
      n_checks++;
      if (gainOut !== 16'd0) begin n_fail++; $display("FAIL decay_end: gainOut %0d required 0", $signed(gainOut)); end
   endtask

   initial begin
      test_reset();
      test_ramp_from_reset();
      test_rounding();
      test_pos_sat();
      test_neg_sat();
      test_async_reset();
      test_retarget();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/output_gain.md
# output_gain

Post-filter output gain stage for the channel strip, directly downstream of the lowpass filter. It consumes the filter's 16-bit signed output at 48 kHz, delivered on the 144 kHz system clock with each sample held for 3 clocks. It applies a selectable gain that ramps toward its target one step per sample, which avoids zipper noise. It then rounds, saturates and presents the result with a one-cycle strobe, plus an optional clip indicator with hold.

## Interface
- RAMP_STEP, 64: Q2.14 gain change per sample while ramping.
- CLIP_HOLD, 4800: samples `clip` stays high after the last saturation event (100 ms at 48 kHz).
- clk_144  in  1  system clock, 3 clocks per audio sample.
- reset  in  1  asynchronous, active-high; the block runs on one clock, clk_144.
- gain_sel  in  3  gain setting index.
- gainIn  in  16  signed sample from the lowpass filter output.
- gainOut  out  16  signed, gained and saturated sample.
- outStrobe  out  1  one-cycle pulse each time gainOut updates.
- clip  out  1  saturation indicator with hold.

## Operation
- Phase counter `ph` counts 0→1→2→0, free-running from reset.
- Gain table, Q2.14 unsigned, 17 bits:
  - 0 → 0 (mute)
  - 1 → 4096
  - 2 → 8192
  - 3 → 11585
  - 4 → 16384 (unity)
  - 5 → 23170
  - 6 → 32768
  - 7 → 49152
- Ramp: on each ph==0 edge, `gain_sel` is sampled and its table entry becomes `target`.
  - curGain moves toward target by RAMP_STEP.
  - If |target−curGain| ≤ RAMP_STEP, curGain snaps to target.
  - Retargeting mid-ramp continues from the present curGain; there is no restart.
- Arithmetic:
  - product = gainIn (16b signed) × curGain (zero-extended to signed 18b), 34-bit signed.
  - round = (product + 8192) >>> 14, arithmetic shift; ties go toward +∞.
  - Saturate to [−32768, 32767].
- Reset values: gainOut=0, outStrobe=0, clip=0, curGain=0, target=0, ph=0, all pipeline registers 0. After reset the gain always ramps up from mute.

## Timing
- ph==0 edge: inReg ← gainIn, and curGain updates.
- ph==1 edge: product ← inReg × curGain. curGain here is the value updated at the preceding ph==0 edge.
- ph==2 edge: gainOut ← sat(round(product)), and outStrobe ← 1. outStrobe is high for exactly one cycle and is cleared at the next edge.
- Latency is 3 clock edges from capture to gainOut. Throughput is one sample per 3 clocks.
- The upstream holds each sample ≥3 clocks, so capture phase alignment is not required.
- gain_sel changes at any phase other than 0 are ignored until the next ph==0 edge.
- Clip handling:
  - A saturation at a ph==2 edge loads holdCnt=CLIP_HOLD and sets clip=1.
  - Each subsequent non-saturating ph==2 edge decrements holdCnt.
  - clip falls when holdCnt reaches 0.
  - A new saturation reloads holdCnt, including while the count is in progress.
- Reset asserted mid-sample clears every register immediately, without waiting for an edge. After reset is released, the first capture occurs at the first clk_144 edge.

## Configuration
- OUTPUT_GAIN_CLIP_EN defined: clip detector and the holdCnt counter, sized $clog2(CLIP_HOLD+1), are built.
- OUTPUT_GAIN_CLIP_EN undefined: clip is tied to 0 and no counter is built. Saturation and all other behaviour are unchanged.

## Structure
- Package `output_gain_pkg`:
  - gain table as a localparam array.
  - Q-format constants: FRAC_BITS=14, ROUND_CONST=8192.
  - SAMPLE_MAX=32767, SAMPLE_MIN=−32768.
  - phase enum PH_CAP, PH_MUL, PH_OUT.
- One sub-module, `gain_ramp`, owns target selection and curGain stepping. Its inputs are clk_144, reset, gain_sel and the capture enable; its output is curGain.

## Test plan
- Ramp from reset, with gain_sel=4 and gainIn=16384 held:
  - First gainOut is 64.
  - gainOut rises by 64 per sample.
  - gainOut reaches 16384 at sample 256 and then holds.
- Attenuation rounding, with gain settled at 2 (8192):
  - gainIn=−3 gives gainOut=−1.
  - gainIn=3 gives 2.
  - gainIn=1000 gives 500.
- Positive saturation: settled gain_sel=6 with gainIn=20000 gives gainOut=32767 and clip=1. Switching to gainIn=0 drops clip exactly 4800 strobes after the last clipped strobe.
- Negative saturation with retrigger: at gain 7, gainIn=−32768 gives −32768. A second clip at hold count 100 reloads the hold to 4800.
- Mid-ramp retarget: starting from 4 with curGain=8192, switching to 0 ramps down 64 per sample and reaches 0 after 128 samples. A sine input decays with no step.
- Async reset between clock edges mid-sample: gainOut, outStrobe and clip go to 0 immediately. Rerun the positive-saturation scenario without OUTPUT_GAIN_CLIP_EN: clip stays 0 and gainOut is still 32767.
